// File: rtl/irq_encoder8_pkg.sv
// Shared definitions for the irq_encoder8 interrupt encoder: default number
// width and the handshake state encoding.
package irq_pkg;

   localparam int LOG2N_DEF = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARB     = 2'd1,
      REQ     = 2'd2,
      RELEASE = 2'd3
   } state_t;

endpackage : irq_pkg

// File: rtl/irq_encoder8_if.sv
// CPU-side four-phase handshake of the interrupt encoder: req/num towards the
// CPU, ack back from it. Number bit 0 is the MSB.
interface irq_encoder8_if #(
   parameter int LOG2N = 3
);
   logic             req;
   logic             ack;
   logic [0:LOG2N-1] num;

   modport master (output req, output num, input ack);
   modport slave  (input req, input num, output ack);
endinterface : irq_encoder8_if

// File: rtl/irq_encoder8_prio_enc.sv
// Combinational priority encoder: index 0 of the vector has the highest
// priority; valid flags that at least one bit is set.
module prio_enc #(
   parameter int LOG2N = 3
) (
   input  logic [0:(2**LOG2N)-1] vec,
   output logic [0:LOG2N-1]      idx,
   output logic                  valid
);
   localparam int N = 2**LOG2N;

   // Scan from the lowest priority upwards so the lowest set index is kept last.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         idx   = vec[k] ? LOG2N'(k) : idx;
         valid = valid | vec[k];
      end
   end
endmodule : prio_enc

// File: rtl/irq_encoder8.sv
// Eight-line interrupt encoder: pending register, priority resolution and a
// four-phase req/ack grant to the CPU. Define IRQ_ENCODER8_EDGE_EN to latch
// only rising edges of irq instead of levels.
module irq_encoder8
   import irq_pkg::*;
#(
   parameter int LOG2N = LOG2N_DEF
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic [0:(2**LOG2N)-1] irq,
   input  logic [0:(2**LOG2N)-1] mask,
   input  logic                  clr,
   irq_encoder8_if.master        cpu,
   output logic [0:(2**LOG2N)-1] pending
);
   localparam int N = 2**LOG2N;

   function automatic logic [0:N-1] onehot(input logic [0:LOG2N-1] sel);
      logic [0:N-1] vec;
      vec      = '0;
      vec[sel] = 1'b1;
      return vec;
   endfunction

   state_t           state_r, next_state_s;
   logic             req_r, next_req_s;
   logic [0:LOG2N-1] num_r, next_num_s;
   logic [0:N-1]     pending_r;
   logic [0:N-1]     set_vec_s, clear_vec_s, masked_s;
   logic [0:LOG2N-1] win_s;
   logic             any_s, ack_fire_s;

`ifdef IRQ_ENCODER8_EDGE_EN
   logic [0:N-1] irq_d_r;

   // One-stage delay of the request lines for rising-edge detection.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         irq_d_r <= '0;
      end else begin
         irq_d_r <= irq;
      end
   end

   assign set_vec_s = irq & ~irq_d_r;
`else
   assign set_vec_s = irq;
`endif

   assign masked_s = pending_r & mask;

   prio_enc #(.LOG2N(LOG2N)) u_prio_enc (
      .vec   (masked_s),
      .idx   (win_s),
      .valid (any_s)
   );

   // Handshake sequencing; num is captured on leaving IDLE and held to the end.
   always_comb begin
      next_state_s = state_r;
      next_req_s   = req_r;
      next_num_s   = num_r;
      ack_fire_s   = 1'b0;
      case (state_r)
         IDLE: begin
            next_req_s = 1'b0;
            if (!clr && any_s) begin
               next_num_s   = win_s;
               next_state_s = ARB;
            end else begin
               next_state_s = IDLE;
            end
         end
         ARB: begin
            if (clr) begin
               next_req_s   = 1'b0;
               next_state_s = IDLE;
            end else begin
               next_req_s   = 1'b1;
               next_state_s = REQ;
            end
         end
         REQ: begin
            if (cpu.ack) begin
               ack_fire_s   = 1'b1;
               next_req_s   = 1'b0;
               next_state_s = RELEASE;
            end else begin
               next_req_s   = 1'b1;
               next_state_s = REQ;
            end
         end
         RELEASE: begin
            next_req_s = 1'b0;
            if (!cpu.ack) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = RELEASE;
            end
         end
         default: begin
            next_req_s   = 1'b0;
            next_state_s = IDLE;
         end
      endcase
   end

   // Clear source: global wipe, or the bit being serviced when ack is taken.
   always_comb begin
      if (clr) begin
         clear_vec_s = '1;
      end else if (ack_fire_s) begin
         clear_vec_s = onehot(num_r);
      end else begin
         clear_vec_s = '0;
      end
   end

   // State, outputs and pending register; set beats clear on the same bit.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_r   <= IDLE;
         req_r     <= 1'b0;
         num_r     <= '0;
         pending_r <= '0;
      end else begin
         state_r   <= next_state_s;
         req_r     <= next_req_s;
         num_r     <= next_num_s;
         pending_r <= (pending_r & ~clear_vec_s) | set_vec_s;
      end
   end

   assign cpu.req = req_r;
   assign cpu.num = num_r;
   assign pending = pending_r;

endmodule : irq_encoder8

// File: tb/tb_irq_encoder8.sv
// Self-checking bench for irq_encoder8: directed handshake scenarios followed
// by randomized traffic, all compared against a transaction-level model.
module tb_irq_encoder8;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic       clr;
   logic [0:7] irq;
   logic [0:7] mask;
   logic [0:7] pending;

   irq_encoder8_if #(.LOG2N(3)) bus ();

   irq_encoder8 #(.LOG2N(3)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .irq     (irq),
      .mask    (mask),
      .clr     (clr),
      .cpu     (bus.master),
      .pending (pending)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;

   // Reference model: pending set, and where the current grant is in its life.
   logic [0:7] m_pend = '0;
   logic [0:7] irq_prev = '0;
   bit         m_req = 1'b0;
   bit         m_settle = 1'b0;
   bit         m_release = 1'b0;
   int         m_num = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [0:7] setv;
      logic [0:7] clrv;
      int         win;
      bit         found;
      if (reset) begin
         m_pend = '0; m_req = 1'b0; m_settle = 1'b0; m_release = 1'b0;
         m_num = 0; irq_prev = '0;
         return;
      end
`ifdef IRQ_ENCODER8_EDGE_EN
      setv = irq & ~irq_prev;
`else
      setv = irq;
`endif
      irq_prev = irq;
      clrv = clr ? 8'hFF : 8'h00;
      found = 1'b0;
      win = 0;
      for (int k = 0; k < 8; k++) begin
         if (!found && m_pend[k] && mask[k]) begin
            found = 1'b1;
            win = k;
         end
      end
      if (m_req) begin
         if (bus.ack) begin
            clrv[m_num] = 1'b1;
            m_req = 1'b0;
            m_release = 1'b1;
         end
      end else if (m_release) begin
         if (!bus.ack) m_release = 1'b0;
      end else if (m_settle) begin
         m_settle = 1'b0;
         m_req = !clr;
      end else if (found && !clr) begin
         m_num = win;
         m_settle = 1'b1;
      end
      m_pend = (m_pend & ~clrv) | setv;
   endtask

   task automatic cycle();
      @(posedge clk_sys);
      model_step();
      #1;
      check_val("req", 32'(bus.req), 32'(m_req));
      check_val("num", 32'(bus.num), 32'(m_num));
      check_val("pending", 32'(pending), 32'(m_pend));
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!bus.req && n < 20) begin
         cycle();
         n++;
      end
      check_val({tag, "_req_seen"}, 32'(bus.req), 32'd1);
   endtask

   task automatic handshake(input string tag, input int exp_num);
      wait_req(tag);
      check_val({tag, "_num"}, 32'(bus.num), 32'(exp_num));
      bus.ack = 1'b1;
      cycle();
      bus.ack = 1'b0;
      cycle();
   endtask

   initial begin
      int grants;
      bit prev_req;
      reset = 1'b1; clr = 1'b0; irq = 8'h00; mask = 8'hFF; bus.ack = 1'b0;
      cycle(); cycle();
      check_val("reset_req", 32'(bus.req), 32'd0);
      check_val("reset_pending", 32'(pending), 32'd0);
      reset = 1'b0;

      // Line 5: two edges from pending to req, ack clears it.
      irq = 8'b00000100;
      cycle();
      check_val("t1_pending", 32'(pending), 32'h04);
      irq = 8'h00;
      cycle();
      check_val("t1_req_early", 32'(bus.req), 32'd0);
      cycle();
      check_val("t1_req", 32'(bus.req), 32'd1);
      check_val("t1_num", 32'(bus.num), 32'd5);
      bus.ack = 1'b1;
      cycle();
      check_val("t1_ack_req", 32'(bus.req), 32'd0);
      check_val("t1_ack_pend", 32'(pending), 32'd0);
      bus.ack = 1'b0;
      cycle();

      // Lines 0 and 7 together: 0 first, then 7 unprompted.
      irq = 8'b10000001;
      cycle();
      irq = 8'h00;
      handshake("t2_first", 0);
      handshake("t2_second", 7);

      // Masked line stays pending until unmasked.
      mask = 8'b01111111;
      irq = 8'b10000000;
      cycle();
      irq = 8'h00;
      for (int i = 0; i < 4; i++) cycle();
      check_val("t3_masked_req", 32'(bus.req), 32'd0);
      check_val("t3_masked_pend", 32'(pending), 32'h80);
      mask = 8'hFF;
      handshake("t3_unmasked", 0);

      // num held during REQ; long ack consumed once.
      irq = 8'b00010000;
      cycle();
      irq = 8'h00;
      wait_req("t4_grant");
      irq = 8'b01000000;
      cycle();
      irq = 8'h00;
      cycle(); cycle();
      check_val("t4_num_hold", 32'(bus.num), 32'd3);
      bus.ack = 1'b1;
      for (int i = 0; i < 5; i++) cycle();
      check_val("t4_ack_held_req", 32'(bus.req), 32'd0);
      check_val("t4_ack_held_pend", 32'(pending), 32'h40);
      bus.ack = 1'b0;
      handshake("t4_next", 1);

      // Same-cycle ack of line 3 and new irq[3]: request survives.
      irq = 8'b00010000;
      cycle();
      irq = 8'h00;
      wait_req("t5_grant");
      irq = 8'b00010000;
      bus.ack = 1'b1;
      cycle();
      check_val("t5_pend_kept", 32'(pending), 32'h10);
      irq = 8'h00;
      bus.ack = 1'b0;
      handshake("t5_regrant", 3);

      // Reset in the middle of a handshake.
      irq = 8'b00100000;
      cycle();
      irq = 8'h00;
      wait_req("t6_grant");
      reset = 1'b1;
      cycle();
      check_val("t6_req", 32'(bus.req), 32'd0);
      check_val("t6_num", 32'(bus.num), 32'd0);
      check_val("t6_pend", 32'(pending), 32'd0);
      reset = 1'b0;
      cycle();

`ifdef IRQ_ENCODER8_EDGE_EN
      // A held-high line yields a single grant.
      grants = 0;
      prev_req = 1'b0;
      irq = 8'b00100000;
      for (int i = 0; i < 30; i++) begin
         bus.ack = bus.req;
         cycle();
         if (bus.req && !prev_req) grants++;
         prev_req = bus.req;
         if (i == 10) irq = 8'h00;
      end
      check_val("edge_grants", 32'(grants), 32'd1);
      irq = 8'h00;
      bus.ack = 1'b0;
      cycle(); cycle();
`else
      grants = 0;
      prev_req = 1'b0;
`endif

      // Randomized traffic with a loosely behaved CPU.
      for (int i = 0; i < 3000; i++) begin
         irq  = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00;
         mask = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'hFF;
         clr  = ($urandom_range(0, 40) == 0);
         reset = ($urandom_range(0, 400) == 0);
         if (m_req) bus.ack = ($urandom_range(0, 2) == 0);
         else if (m_release) bus.ack = ($urandom_range(0, 1) == 0) ? 1'b0 : bus.ack;
         else bus.ack = ($urandom_range(0, 7) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_irq_encoder8
